ofdm_cp_insert: RTL and testbench
=================================

# ofdm_cp_insert

Cyclic-prefix inserter that sits directly downstream of `top_frame`. It consumes the frame generator's time-domain I/Q stream, where `sop` marks sample 0 of each N_FFT-sample symbol. It emits each symbol prefixed by a copy of its last CP_LEN samples toward the DAC interface. A ping-pong buffer absorbs one symbol while the previous one is being played out, and `in_ready` throttles the upstream stage.

## Interface
- N_FFT, 64, samples per OFDM symbol (power of two)
- CP_LEN, 16, cyclic-prefix length, 1..N_FFT-1
- W, 16, signed sample width of I and Q
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  global clock enable; low freezes all state and outputs
- in_valid  in  1  input sample valid
- in_sop  in  1  first sample of a symbol; meaningful only with in_valid
- in_I, in_Q  in  W  signed input sample
- in_ready  out  1  block can accept a sample this cycle
- out_valid  out  1  output sample valid
- out_sop  out  1  first CP sample of an output symbol
- out_eop  out  1  last body sample of an output symbol
- out_I, out_Q  out  W  signed output sample

## Operation
- A sample is accepted when `enable && in_valid && in_ready`.
- The buffer has two banks of N_FFT samples each. Each bank has a `full` flag.
- Write FSM:
  - W_WAIT: accepted samples without `in_sop` are discarded. An accepted `in_sop` writes address 0 and moves to W_FILL.
  - W_FILL: writes addresses 1..N_FFT-1. After address N_FFT-1 it sets `full[wbank]`, toggles `wbank`, and returns to W_WAIT.
  - An accepted `in_sop` in W_FILL aborts the partial symbol. That sample is rewritten at address 0 of the same bank, and the state stays W_FILL.
- `in_ready = !full[wbank]`.
- Read FSM:
  - R_IDLE: moves to R_CP when `full[rbank]` is set.
  - R_CP: reads addresses N_FFT-CP_LEN..N_FFT-1.
  - R_BODY: reads addresses 0..N_FFT-1. On the last read it clears `full[rbank]` and toggles `rbank`. If the other bank is already full, it goes straight to R_CP; otherwise it goes to R_IDLE.
- Arithmetic: samples pass bit-exact with no scaling. Address counters are log2(N_FFT) bits.
- Reset values: every output is 0. `in_ready` deasserts while reset is asserted and is 1 after release. Both `full` flags are 0, both banks are selected at bank 0, and both FSMs sit in their idle states (W_WAIT, R_IDLE).
- Reset mid-operation discards all buffered data. A partially emitted symbol is truncated with no `out_eop`.
- When a write completes into bank b in the same cycle that the read releases bank b', the two flag updates are independent and both take effect.

## Timing
- RAM read is registered: `out_*` appear 1 cycle after the read address is issued.
- Latency: the last sample of a symbol is accepted at cycle t. `full` is set at t+1, the first read is issued at t+1, and `out_sop` with `out_valid` appears at t+2.
- Each symbol occupies exactly N_FFT+CP_LEN consecutive `out_valid` cycles. Back-to-back full banks produce no gap between symbols.
- `out_sop` and `out_eop` are single-cycle pulses, qualified by `out_valid`.
- Sustained input rate is at most N_FFT/(N_FFT+CP_LEN) samples per cycle. `in_ready` enforces this.
- With `enable` low there are no state changes and outputs hold. Outputs resume exactly where they stopped.

## Configuration
- `OFDM_CPI_ERRCNT_EN` defined:
  - Adds output port `err_count` (8 bits).
  - It counts W_FILL aborts caused by a mid-symbol `in_sop` and saturates at 255.
  - It is cleared only by reset.
- Not defined: the port and counter are absent. Abort behaviour is unchanged.

## Structure
- Shared package `ofdm_pkg` holds:
  - N_FFT, CP_LEN and W defaults
  - Write FSM state typedef (W_WAIT, W_FILL)
  - Read FSM state typedef (R_IDLE, R_CP, R_BODY)
- Sub-module `ofdm_cpi_ram`: simple dual-port RAM of 2·N_FFT words × 2W bits. It has one write port and one registered read port. The bank bit is the address MSB.

## Test plan
- Single symbol, I=k, Q=-k for k=0..63 -> 80 valid outputs.
  - Outputs are I=48..63, then I=0..63, with Q negated.
  - `out_sop` on output 1 and `out_eop` on output 80.
  - First output arrives 2 cycles after the last input is accepted.
- Three symbols driven with continuous `in_valid` -> 240 contiguous `out_valid` cycles. `in_ready` drops while both banks are full and no samples are lost.
- `in_sop` reasserted at sample 30, then a full 64-sample symbol -> exactly one 80-sample output from the second symbol; `err_count`=1 when the macro is enabled.
- Samples with `in_valid` and no preceding `in_sop` -> no output and no `full` set.
- Reset asserted during output sample 40 -> all outputs 0 immediately and `in_ready`=0 while held. After release a fresh symbol produces the correct 80 samples.
- `enable` low for 5 cycles mid-CP -> outputs hold. The sequence then resumes with no skipped or repeated samples.

Source files
------------

// File: rtl/ofdm_pkg.sv
// Shared types and sizing for the OFDM cyclic-prefix inserter.
// Optional build macro: OFDM_CPI_ERRCNT_EN (adds the abort counter port).
package ofdm_pkg;

  localparam int unsigned N_FFT  = 64;
  localparam int unsigned CP_LEN = 16;
  localparam int unsigned W      = 16;

  localparam int unsigned AW    = $clog2(N_FFT);
  localparam int unsigned DW    = 2 * W;
  localparam int unsigned ERR_W = 8;

  // One complex time-domain sample
  typedef struct packed {
    logic signed [W-1:0] i;
    logic signed [W-1:0] q;
  } iq_t;

  typedef enum logic {
    W_WAIT,
    W_FILL
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_CP,
    R_BODY
  } rstate_e;

  // Saturating increment for the abort counter
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/ofdm_cp_insert_if.sv
// Sample-stream bundle between the frame generator, the CP inserter and the DAC side.
interface ofdm_cp_insert_if;
  import ofdm_pkg::*;

  logic in_valid;
  logic in_sop;
  iq_t  in_iq;
  logic in_ready;

  logic out_valid;
  logic out_sop;
  logic out_eop;
  iq_t  out_iq;

  // Stimulus/upstream side
  modport master (
    output in_valid, in_sop, in_iq,
    input  in_ready, out_valid, out_sop, out_eop, out_iq
  );

  // CP inserter side
  modport slave (
    input  in_valid, in_sop, in_iq,
    output in_ready, out_valid, out_sop, out_eop, out_iq
  );

endinterface

// File: rtl/ofdm_cpi_ram.sv
// Ping-pong sample store: 2*N_FFT words, one write port, one registered read port.
// Address MSB selects the bank.
module ofdm_cpi_ram
  import ofdm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en_i,
  input  logic [AW:0] wr_addr_i,
  input  iq_t         wr_data_i,
  input  logic        rd_en_i,
  input  logic [AW:0] rd_addr_i,
  output iq_t         rd_data_o
);

  localparam int unsigned DEPTH = 2 * N_FFT;

  iq_t mem_q [0:DEPTH-1];
  iq_t rd_data_q;

  // Storage array, no reset so it maps onto a RAM macro
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read; holds its value whenever no read is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ofdm_cp_insert.sv
// Cyclic-prefix inserter: buffers each N_FFT-sample symbol in a ping-pong RAM and
// replays it prefixed by its last CP_LEN samples.
// Optional build macro: OFDM_CPI_ERRCNT_EN adds err_count_o, a saturating count of
// symbols aborted by a mid-symbol sop.
module ofdm_cp_insert
  import ofdm_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_i,
  ofdm_cp_insert_if.slave     s_if
`ifdef OFDM_CPI_ERRCNT_EN
  ,
  output logic [ERR_W-1:0]    err_count_o
`endif
);

  localparam logic [AW-1:0] ADDR_LAST = AW'(N_FFT - 1);
  localparam logic [AW-1:0] CP_START  = AW'(N_FFT - CP_LEN);
  localparam logic [AW-1:0] CP_NEXT   = AW'(N_FFT - CP_LEN + 1);

  // Write side state
  wstate_e       wstate_q, wstate_d;
  logic [AW-1:0] wcnt_q,   wcnt_d;
  logic          wbank_q,  wbank_d;

  // Read side state
  rstate_e       rstate_q, rstate_d;
  logic [AW-1:0] rcnt_q,   rcnt_d;
  logic          rbank_q,  rbank_d;

  // Shared bank status
  logic [1:0]    full_q,   full_d;
  logic          ready_q,  ready_d;

  // Output framing registers (data comes from the RAM read register)
  logic          out_valid_q, out_sop_q, out_eop_q;

  // Per-cycle control
  logic          accept;
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic          wr_done;
  logic          abort;
  logic          rd_en;
  logic [AW:0]   rd_addr;
  logic          rd_sop;
  logic          rd_eop;
  logic          rd_done;
  iq_t           rd_data;

  assign accept = enable_i && s_if.in_valid && ready_q;

  // Write FSM: wait for sop, then fill one bank; a new sop restarts the bank
  always_comb begin
    wstate_d = wstate_q;
    wcnt_d   = wcnt_q;
    wbank_d  = wbank_q;
    wr_en    = 1'b0;
    wr_addr  = {wbank_q, wcnt_q};
    wr_done  = 1'b0;
    abort    = 1'b0;
    if (accept) begin
      case (wstate_q)
        W_WAIT: begin
          if (s_if.in_sop) begin
            wr_en    = 1'b1;
            wr_addr  = {wbank_q, AW'(0)};
            wcnt_d   = AW'(1);
            wstate_d = W_FILL;
          end
        end
        W_FILL: begin
          wr_en = 1'b1;
          if (s_if.in_sop) begin
            abort   = 1'b1;
            wr_addr = {wbank_q, AW'(0)};
            wcnt_d  = AW'(1);
          end else if (wcnt_q == ADDR_LAST) begin
            wr_done  = 1'b1;
            wbank_d  = ~wbank_q;
            wcnt_d   = AW'(0);
            wstate_d = W_WAIT;
          end else begin
            wcnt_d = wcnt_q + AW'(1);
          end
        end
        default: wstate_d = W_WAIT;
      endcase
    end
  end

  // Read FSM: CP tail first, then the whole body; chains straight into a waiting bank
  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_q;
    rbank_d  = rbank_q;
    rd_en    = 1'b0;
    rd_addr  = {rbank_q, rcnt_q};
    rd_sop   = 1'b0;
    rd_eop   = 1'b0;
    rd_done  = 1'b0;
    if (enable_i) begin
      case (rstate_q)
        R_IDLE: begin
          if (full_q[rbank_q]) begin
            rd_en   = 1'b1;
            rd_addr = {rbank_q, CP_START};
            rd_sop  = 1'b1;
            if (CP_START == ADDR_LAST) begin
              rstate_d = R_BODY;
              rcnt_d   = AW'(0);
            end else begin
              rstate_d = R_CP;
              rcnt_d   = CP_NEXT;
            end
          end
        end
        R_CP: begin
          rd_en  = 1'b1;
          // Only reached at CP_START when chained from a previous body
          rd_sop = (rcnt_q == CP_START);
          if (rcnt_q == ADDR_LAST) begin
            rstate_d = R_BODY;
            rcnt_d   = AW'(0);
          end else begin
            rcnt_d = rcnt_q + AW'(1);
          end
        end
        R_BODY: begin
          rd_en = 1'b1;
          if (rcnt_q == ADDR_LAST) begin
            rd_eop  = 1'b1;
            rd_done = 1'b1;
            rbank_d = ~rbank_q;
            if (full_q[~rbank_q]) begin
              rstate_d = R_CP;
              rcnt_d   = CP_START;
            end else begin
              rstate_d = R_IDLE;
              rcnt_d   = AW'(0);
            end
          end else begin
            rcnt_d = rcnt_q + AW'(1);
          end
        end
        default: rstate_d = R_IDLE;
      endcase
    end
  end

  // Bank flags: write completion and read release touch different banks
  always_comb begin
    full_d = full_q;
    if (wr_done) begin
      full_d[wbank_q] = 1'b1;
    end
    if (rd_done) begin
      full_d[rbank_q] = 1'b0;
    end
    ready_d = !full_d[wbank_d];
  end

  // State registers; the next-state logic already holds everything when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q <= W_WAIT;
      wcnt_q   <= '0;
      wbank_q  <= 1'b0;
      rstate_q <= R_IDLE;
      rcnt_q   <= '0;
      rbank_q  <= 1'b0;
      full_q   <= '0;
      ready_q  <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      wcnt_q   <= wcnt_d;
      wbank_q  <= wbank_d;
      rstate_q <= rstate_d;
      rcnt_q   <= rcnt_d;
      rbank_q  <= rbank_d;
      full_q   <= full_d;
      ready_q  <= ready_d;
    end
  end

  // Output framing, aligned with the RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else if (enable_i) begin
      out_valid_q <= rd_en;
      out_sop_q   <= rd_sop;
      out_eop_q   <= rd_eop;
    end
  end

  ofdm_cpi_ram u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (s_if.in_iq),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign s_if.in_ready  = ready_q;
  assign s_if.out_valid = out_valid_q;
  assign s_if.out_sop   = out_sop_q;
  assign s_if.out_eop   = out_eop_q;
  assign s_if.out_iq    = rd_data;

`ifdef OFDM_CPI_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // Count aborted partial symbols, saturating
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (abort) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  // Abort counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_ofdm_cp_insert.sv
// Self-checking bench for ofdm_cp_insert: random and ramp symbols against a
// queue-based reference of "last CP_LEN samples, then the whole symbol".
module tb_ofdm_cp_insert;
  import ofdm_pkg::*;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic enable = 1'b1;

  ofdm_cp_insert_if bus ();

`ifdef OFDM_CPI_ERRCNT_EN
  logic [ERR_W-1:0] err_count;
`endif

  ofdm_cp_insert dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (enable),
    .s_if     (bus)
`ifdef OFDM_CPI_ERRCNT_EN
    ,
    .err_count_o (err_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [33:0] exp_q[$];
  iq_t         cur[$];
  bit          in_sym       = 1'b0;
  int          model_aborts = 0;

  function automatic void model_accept(input bit sop, input iq_t s);
    if (sop) begin
      if (in_sym) model_aborts++;
      cur.delete();
      in_sym = 1'b1;
    end
    if (in_sym) begin
      cur.push_back(s);
      if (cur.size() == N_FFT) begin
        for (int k = N_FFT - CP_LEN; k < N_FFT; k++)
          exp_q.push_back({k == (N_FFT - CP_LEN), 1'b0, cur[k]});
        for (int k = 0; k < N_FFT; k++)
          exp_q.push_back({1'b0, k == (N_FFT - 1), cur[k]});
        cur.delete();
        in_sym = 1'b0;
      end
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    cur.delete();
    in_sym       = 1'b0;
    model_aborts = 0;
  endfunction

  // ---------------- output collector ----------------
  longint cyc     = 0;
  bit     en_last = 1'b1;
  int     out_cnt = 0;
  int     sop_cnt = 0;
  int     run     = 0;
  int     max_run = 0;
  int     n_spurious = 0;
  int     n_timeouts = 0;
  longint last_sop_cyc = 0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    en_last <= enable;
  end

  // A new output sample exists only after an enabled clock edge
  always @(negedge clk) begin
    if (rst_n && en_last) begin
      if (bus.out_valid) begin
        out_cnt++;
        run++;
        if (run > max_run) max_run = run;
        if (bus.out_sop) begin
          sop_cnt++;
          last_sop_cyc = cyc;
        end
        if (exp_q.size() == 0) n_spurious++;
        else chk("out_sample", {bus.out_sop, bus.out_eop, bus.out_iq}, exp_q.pop_front());
      end else begin
        run = 0;
      end
    end
  end

  // ---------------- driver ----------------
  bit     rand_en      = 1'b0;
  bit     saw_stall    = 1'b0;
  longint last_acc_cyc = 0;

  task automatic send(input bit sop, input iq_t s);
    bit acc;
    bus.in_valid = 1'b1;
    bus.in_sop   = sop;
    bus.in_iq    = s;
    for (int n = 0; n < 2000; n++) begin
      if (rand_en) enable = ($urandom_range(0, 7) != 0);
      acc = enable && bus.in_ready;
      if (enable && !bus.in_ready) saw_stall = 1'b1;
      if (acc) begin
        model_accept(sop, s);
        last_acc_cyc = cyc;
      end
      @(posedge clk);
      @(negedge clk);
      if (acc) return;
    end
    n_timeouts++;
  endtask

  task automatic send_symbol(input int len, input bit first_sop, input bit ramp, input int gap_max);
    iq_t s;
    for (int k = 0; k < len; k++) begin
      if (ramp) begin
        s.i = W'(k);
        s.q = W'(-k);
      end else begin
        s.i = W'($urandom);
        s.q = W'($urandom);
      end
      send(first_sop && (k == 0), s);
      if (gap_max > 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
  endtask

  task automatic drain(input int budget);
    bus.in_valid = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    repeat (4) @(negedge clk);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("no_spurious_or_timeout", 64'(n_spurious + n_timeouts), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int o0, s0;
  logic [34:0] snap;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_iq    = '0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_flags", {bus.out_sop, bus.out_eop}, 0);
    chk("rst_out_iq", bus.out_iq, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", bus.in_ready, 1);
`ifdef OFDM_CPI_ERRCNT_EN
    chk("rst_err_count", err_count, 0);
`endif

    // 1: single ramp symbol
    o0 = out_cnt;
    send_symbol(N_FFT, 1'b1, 1'b1, 0);
    drain(400);
    chk("t1_count", 64'(out_cnt - o0), 64'(N_FFT + CP_LEN));
    chk("t1_latency", 64'(last_sop_cyc - last_acc_cyc), 64'd2);

    // 2: three back-to-back symbols with continuous valid
    o0 = out_cnt; s0 = sop_cnt; max_run = 0; saw_stall = 1'b0;
    repeat (3) send_symbol(N_FFT, 1'b1, 1'b0, 0);
    drain(600);
    chk("t2_count", 64'(out_cnt - o0), 64'(3 * (N_FFT + CP_LEN)));
    chk("t2_contiguous", 64'(max_run), 64'(3 * (N_FFT + CP_LEN)));
    chk("t2_sops", 64'(sop_cnt - s0), 64'd3);
    chk("t2_stalled", 64'(saw_stall), 64'd1);

    // 3: abort at sample 30, then a complete symbol
    o0 = out_cnt; s0 = sop_cnt;
    send_symbol(30, 1'b1, 1'b0, 0);
    send_symbol(N_FFT, 1'b1, 1'b0, 0);
    drain(400);
    chk("t3_count", 64'(out_cnt - o0), 64'(N_FFT + CP_LEN));
    chk("t3_sops", 64'(sop_cnt - s0), 64'd1);
`ifdef OFDM_CPI_ERRCNT_EN
    chk("t3_err_count", err_count, 64'(model_aborts));
`endif

    // 4: samples without any sop are dropped
    o0 = out_cnt;
    send_symbol(20, 1'b0, 1'b0, 1);
    repeat (10) @(negedge clk);
    chk("t4_no_output", 64'(out_cnt - o0), 64'd0);
    chk("t4_ready", bus.in_ready, 1);

    // 5: reset during output sample 40
    o0 = out_cnt;
    send_symbol(N_FFT, 1'b1, 1'b0, 0);
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      #1;
      if (out_cnt - o0 >= 40) break;
    end
    chk("t5_reached40", 64'(out_cnt - o0), 64'd40);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_outputs", {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_iq}, 0);
    model_reset();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("t5_ready_in_rst", bus.in_ready, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_ready_release", bus.in_ready, 1);
`ifdef OFDM_CPI_ERRCNT_EN
    chk("t5_err_cleared", err_count, 0);
`endif
    o0 = out_cnt;
    send_symbol(N_FFT, 1'b1, 1'b1, 0);
    drain(400);
    chk("t5_count", 64'(out_cnt - o0), 64'(N_FFT + CP_LEN));

    // 6: enable low for 5 cycles mid-CP
    o0 = out_cnt;
    send_symbol(N_FFT, 1'b1, 1'b0, 0);
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      #1;
      if (out_cnt - o0 >= 8) break;
    end
    snap   = {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_iq};
    enable = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      #1;
      chk("t6_hold", {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_iq}, snap);
    end
    enable = 1'b1;
    drain(400);
    chk("t6_count", 64'(out_cnt - o0), 64'(N_FFT + CP_LEN));

    // 7: random gaps and random enable
    o0 = out_cnt; s0 = sop_cnt;
    rand_en = 1'b1;
    repeat (4) send_symbol(N_FFT, 1'b1, 1'b0, 3);
    rand_en = 1'b0;
    enable  = 1'b1;
    drain(1500);
    chk("t7_count", 64'(out_cnt - o0), 64'(4 * (N_FFT + CP_LEN)));
    chk("t7_sops", 64'(sop_cnt - s0), 64'd4);
`ifdef OFDM_CPI_ERRCNT_EN
    chk("final_err_count", err_count, 64'(model_aborts));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
